// File: rtl/attack_scan_ctl.sv
// Shares one 2-cycle attack-detector array between the move generator (req0) and the evaluator (req1):
// round-robin grant, one board in flight, tagged response with timeout on a lost array result.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 256
`endif

module attack_scan_ctl #(
  parameter int TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              req_valid,
  input  logic [`BOARD_WIDTH-1:0] req_board0,
  input  logic [`BOARD_WIDTH-1:0] req_board1,
  output logic [1:0]              req_ready,
  output logic [`BOARD_WIDTH-1:0] board_out,
  output logic                    board_valid_out,
  input  logic [63:0]             arr_w_attacking,
  input  logic [63:0]             arr_b_attacking,
  input  logic [63:0]             arr_w_opp_check,
  input  logic [63:0]             arr_b_opp_check,
  input  logic                    arr_valid,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_id,
  output logic [63:0]             rsp_w_attacks,
  output logic [63:0]             rsp_b_attacks,
  output logic                    rsp_white_in_check,
  output logic                    rsp_black_in_check,
  output logic                    rsp_err
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          last_grant;
  logic [TW-1:0] timer;
  logic [1:0]    grant;
  logic          accept;
  logic          timeout_hit;

  assign accept      = |(grant & req_valid);
  assign timeout_hit = (timer == TW'(TIMEOUT - 1));
  assign req_ready   = grant;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next      = state;
    grant           = 2'b00;
    board_valid_out = 1'b0;
    case (state)
      IDLE: begin
        // On a tie, serve whoever was not granted last.
        if (req_valid == 2'b11) begin
          grant = last_grant ? 2'b01 : 2'b10;
        end else begin
          grant = req_valid;
        end
        if (accept) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        board_valid_out = 1'b1;
        state_next      = WAIT;
      end
      WAIT: begin
        if (arr_valid || timeout_hit) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant         <= 1'b1;
      timer              <= '0;
      board_out          <= '0;
      rsp_valid          <= 1'b0;
      rsp_id             <= 1'b0;
      rsp_w_attacks      <= '0;
      rsp_b_attacks      <= '0;
      rsp_white_in_check <= 1'b0;
      rsp_black_in_check <= 1'b0;
      rsp_err            <= 1'b0;
    end else begin
      // Timer counts from the strobe cycle, so a timeout responds TIMEOUT cycles after the strobe.
      if (state == ISSUE || state == WAIT) begin
        timer <= timer + TW'(1);
      end else begin
        timer <= '0;
      end

      if (state == IDLE && accept) begin
        board_out  <= grant[1] ? req_board1 : req_board0;
        rsp_id     <= grant[1];
        last_grant <= grant[1];
      end

      if (state == WAIT) begin
        if (arr_valid) begin
          rsp_w_attacks      <= arr_w_attacking;
          rsp_b_attacks      <= arr_b_attacking;
          rsp_white_in_check <= |arr_b_opp_check;
          rsp_black_in_check <= |arr_w_opp_check;
          rsp_err            <= 1'b0;
          rsp_valid          <= 1'b1;
        end else if (timeout_hit) begin
          rsp_w_attacks      <= '0;
          rsp_b_attacks      <= '0;
          rsp_white_in_check <= 1'b0;
          rsp_black_in_check <= 1'b0;
          rsp_err            <= 1'b1;
          rsp_valid          <= 1'b1;
        end
      end

      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_attack_scan_ctl.sv
// Testbench for attack_scan_ctl: behavioural chess attack array plus a queue scoreboard checked
// by a monitor that is independent of the stimulus process.
`ifndef BOARD_WIDTH
`define BOARD_WIDTH 256
`endif

module tb_attack_scan_ctl;
  localparam int TIMEOUT = 16;
  localparam int BW      = `BOARD_WIDTH;
  localparam int NEVER   = 255;

  typedef logic [BW-1:0] board_t;
  typedef struct {
    logic        id;
    logic        err;
    logic [63:0] wa;
    logic [63:0] ba;
    logic        wchk;
    logic        bchk;
    int          tag;
  } rsp_t;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  board_t      req_board0;
  board_t      req_board1;
  logic [1:0]  req_ready;
  board_t      board_out;
  logic        board_valid_out;
  logic [63:0] arr_w_attacking;
  logic [63:0] arr_b_attacking;
  logic [63:0] arr_w_opp_check;
  logic [63:0] arr_b_opp_check;
  logic        arr_valid;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [63:0] rsp_w_attacks;
  logic [63:0] rsp_b_attacks;
  logic        rsp_white_in_check;
  logic        rsp_black_in_check;
  logic        rsp_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int next_delay = 2;
  int next_tag   = 0;
  bit bound_hit  = 1'b0;

  // Written only by the monitor
  int     scan_delay = 2;
  bit     busy = 1'b0;
  logic   m_last = 1'b1;
  int     cur_due = 0;
  int     bvo_due = -1;
  board_t cur_board = '0;
  bit     holding = 1'b0;
  logic [BW-1:0] snap = '0;
  rsp_t   sb[$];

  // Written only by the array model
  bit     pend = 1'b0;
  int     pend_cycle = 0;
  board_t pend_board = '0;

  attack_scan_ctl #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_board0(req_board0),
    .req_board1(req_board1), .req_ready(req_ready), .board_out(board_out),
    .board_valid_out(board_valid_out), .arr_w_attacking(arr_w_attacking),
    .arr_b_attacking(arr_b_attacking), .arr_w_opp_check(arr_w_opp_check),
    .arr_b_opp_check(arr_b_opp_check), .arr_valid(arr_valid), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_w_attacks(rsp_w_attacks),
    .rsp_b_attacks(rsp_b_attacks), .rsp_white_in_check(rsp_white_in_check),
    .rsp_black_in_check(rsp_black_in_check), .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit on_board(input int r, input int c);
    return (r >= 0) && (r < 8) && (c >= 0) && (c < 8);
  endfunction

  // Piece codes: low 3 bits 1..6 = P N B R Q K, bit 3 = black; 0 = empty.
  function automatic logic [63:0] attack_map(input board_t b, input logic side);
    logic [63:0] m;
    logic [3:0]  p;
    logic [3:0]  q;
    int r, c, rr, cc;
    int kdr[8] = '{1, 2, 2, 1, -1, -2, -2, -1};
    int kdc[8] = '{2, 1, -1, -2, -2, -1, 1, 2};
    int dr[8]  = '{1, -1, 0, 0, 1, 1, -1, -1};
    int dc[8]  = '{0, 0, 1, -1, 1, -1, 1, -1};
    m = '0;
    for (int sq = 0; sq < 64; sq++) begin
      p = b[sq*4 +: 4];
      if (p[2:0] == 3'd0 || p[2:0] == 3'd7 || p[3] != side) continue;
      r = sq / 8;
      c = sq % 8;
      case (p[2:0])
        3'd1: for (int k = 0; k < 2; k++) begin
          rr = side ? r - 1 : r + 1;
          cc = (k == 0) ? c - 1 : c + 1;
          if (on_board(rr, cc)) m[rr*8+cc] = 1'b1;
        end
        3'd2: for (int k = 0; k < 8; k++) begin
          rr = r + kdr[k];
          cc = c + kdc[k];
          if (on_board(rr, cc)) m[rr*8+cc] = 1'b1;
        end
        3'd6: for (int k = 0; k < 8; k++) begin
          rr = r + dr[k];
          cc = c + dc[k];
          if (on_board(rr, cc)) m[rr*8+cc] = 1'b1;
        end
        default: for (int k = 0; k < 8; k++) begin
          if ((p[2:0] == 3'd3 && k < 4) || (p[2:0] == 3'd4 && k >= 4)) continue;
          rr = r + dr[k];
          cc = c + dc[k];
          while (on_board(rr, cc)) begin
            m[rr*8+cc] = 1'b1;
            q = b[(rr*8+cc)*4 +: 4];
            if (q[2:0] != 3'd0) break;
            rr = rr + dr[k];
            cc = cc + dc[k];
          end
        end
      endcase
    end
    return m;
  endfunction

  function automatic logic [63:0] king_mask(input board_t b, input logic [3:0] k);
    logic [63:0] m;
    for (int sq = 0; sq < 64; sq++) m[sq] = (b[sq*4 +: 4] == k);
    return m;
  endfunction

  function automatic board_t rand_board();
    board_t b;
    logic [3:0] p;
    b = '0;
    for (int sq = 0; sq < 64; sq++) begin
      if ($urandom_range(0, 4) == 0) begin
        p = 4'($urandom_range(1, 6));
        p[3] = 1'($urandom_range(0, 1));
        b[sq*4 +: 4] = p;
      end
    end
    return b;
  endfunction

  function automatic board_t start_board();
    board_t b;
    int back[8] = '{4, 2, 3, 5, 6, 3, 2, 4};
    b = '0;
    for (int c = 0; c < 8; c++) begin
      b[(0*8+c)*4 +: 4] = 4'(back[c]);
      b[(1*8+c)*4 +: 4] = 4'd1;
      b[(6*8+c)*4 +: 4] = 4'd9;
      b[(7*8+c)*4 +: 4] = 4'(back[c] + 8);
    end
    return b;
  endfunction

  function automatic board_t rook_board();
    board_t b;
    b = '0;
    b[60*4 +: 4] = 4'hE;
    b[4*4 +: 4]  = 4'h4;
    b[0*4 +: 4]  = 4'h6;
    return b;
  endfunction

  // Tie-break: grant the requester that was not served last.
  function automatic logic [1:0] arb(input logic [1:0] v, input logic last);
    logic [1:0] g;
    g = 2'b00;
    if (v == 2'b11) g[!last] = 1'b1;
    else g = v;
    return g;
  endfunction

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Array model: result appears scan_delay cycles after the strobe (never for NEVER), garbage otherwise.
  always @(posedge clk) begin
    logic [63:0] wa, ba;
    #1;
    arr_valid       = 1'b0;
    arr_w_attacking = {$urandom, $urandom};
    arr_b_attacking = {$urandom, $urandom};
    arr_w_opp_check = {$urandom, $urandom};
    arr_b_opp_check = {$urandom, $urandom};
    if (pend && cyc == pend_cycle) begin
      wa = attack_map(pend_board, 1'b0);
      ba = attack_map(pend_board, 1'b1);
      arr_valid       = 1'b1;
      arr_w_attacking = wa;
      arr_b_attacking = ba;
      arr_w_opp_check = wa & king_mask(pend_board, 4'hE);
      arr_b_opp_check = ba & king_mask(pend_board, 4'h6);
      pend = 1'b0;
    end
    if (board_valid_out && scan_delay != NEVER) begin
      pend       = 1'b1;
      pend_cycle = cyc + scan_delay;
      pend_board = board_out;
    end
  end

  // Monitor: reference model of grants/timing plus scoreboard of responses.
  always @(negedge clk) begin
    logic [1:0]  exp_ready;
    bit          m_valid;
    rsp_t        it;
    logic [63:0] wa, ba;
    logic [BW-1:0] now_rsp;
    now_rsp = BW'({rsp_id, rsp_err, rsp_white_in_check, rsp_black_in_check, rsp_w_attacks, rsp_b_attacks});
    if (reset) begin
      check("reset_state", BW'({|board_out, |rsp_w_attacks, |rsp_b_attacks, req_ready, board_valid_out,
                                rsp_valid, rsp_id, rsp_err, rsp_white_in_check, rsp_black_in_check}), '0);
      busy = 1'b0; m_last = 1'b1; bvo_due = -1; holding = 1'b0;
      sb.delete();
    end else begin
      exp_ready = busy ? 2'b00 : arb(req_valid, m_last);
      m_valid   = busy && (cyc >= cur_due);
      check("req_ready", BW'(req_ready), BW'(exp_ready));
      check("rsp_valid", BW'(rsp_valid), BW'(m_valid));
      check("board_valid_out", BW'(board_valid_out), BW'(cyc == bvo_due));
      if (cyc == bvo_due) check("board_out", board_out, cur_board);
      check("wait_bound", BW'(bound_hit), '0);

      if (rsp_valid) begin
        if (!holding) begin
          if (sb.size() == 0) begin
            check("unexpected_rsp", BW'(1), '0);
          end else begin
            it = sb.pop_front();
            check("rsp_id", BW'(rsp_id), BW'(it.id));
            check("rsp_err", BW'(rsp_err), BW'(it.err));
            check("rsp_w_attacks", BW'(rsp_w_attacks), BW'(it.wa));
            check("rsp_b_attacks", BW'(rsp_b_attacks), BW'(it.ba));
            check("white_in_check", BW'(rsp_white_in_check), BW'(it.wchk));
            check("black_in_check", BW'(rsp_black_in_check), BW'(it.bchk));
            if (it.tag == 1) begin
              check("startpos_row3", BW'(rsp_w_attacks[23:16]), BW'(8'hFF));
              check("startpos_checks", BW'({rsp_white_in_check, rsp_black_in_check, rsp_id}), '0);
            end
            if (it.tag == 3)
              check("rook_check", BW'({rsp_black_in_check, rsp_white_in_check, rsp_w_attacks[60], rsp_id}),
                    BW'(4'b1011));
            if (it.tag == 5)
              check("timeout_zero", BW'({rsp_err, |rsp_w_attacks, |rsp_b_attacks,
                                         rsp_white_in_check, rsp_black_in_check}), BW'(5'b10000));
          end
        end else begin
          check("rsp_stable", now_rsp, snap);
        end
        snap = now_rsp;
      end
      holding = rsp_valid && !rsp_ready;

      if (!busy && exp_ready != 2'b00) begin
        busy       = 1'b1;
        m_last     = exp_ready[1];
        cur_board  = exp_ready[1] ? req_board1 : req_board0;
        scan_delay = next_delay;
        wa = attack_map(cur_board, 1'b0);
        ba = attack_map(cur_board, 1'b1);
        it.id   = exp_ready[1];
        it.err  = (next_delay >= TIMEOUT);
        it.tag  = next_tag;
        it.wa   = it.err ? 64'd0 : wa;
        it.ba   = it.err ? 64'd0 : ba;
        it.wchk = !it.err && |(ba & king_mask(cur_board, 4'h6));
        it.bchk = !it.err && |(wa & king_mask(cur_board, 4'hE));
        cur_due = cyc + 1 + (it.err ? TIMEOUT : next_delay + 1);
        bvo_due = cyc + 1;
        sb.push_back(it);
      end else if (m_valid && rsp_ready) begin
        busy = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 2'b00;
    repeat (n) tick();
  endtask

  task automatic run(input logic [1:0] v, input int n, input int d, input int tag,
                     input int stall, input bit rr_rand, input bit rand_boards);
    int got = 0;
    int guard = 0;
    int st = stall;
    bit acc;
    req_valid = v; next_delay = d; next_tag = tag;
    while (got < n && guard < 400) begin
      rsp_ready = (st > 0) ? 1'b0 : (rr_rand ? ($urandom_range(0, 2) != 0) : 1'b1);
      @(negedge clk);
      acc = |(req_valid & req_ready);
      if (rsp_valid && rsp_ready) got++;
      else if (rsp_valid && st > 0) st--;
      tick();
      guard++;
      if (acc && rand_boards) begin
        req_board0 = rand_board();
        req_board1 = rand_board();
      end
    end
    if (guard >= 400) bound_hit = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 1'b1;
  endtask

  function automatic int pick_delay();
    int r;
    r = $urandom_range(0, 9);
    if (r < 7) return $urandom_range(1, 6);
    if (r == 7) return TIMEOUT - 1;
    if (r == 8) return TIMEOUT;
    return NEVER;
  endfunction

  initial begin
    logic [1:0] v;
    int guard;
    reset = 1'b1; req_valid = 2'b00; req_board0 = '0; req_board1 = '0; rsp_ready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    req_board0 = start_board();
    run(2'b01, 1, 2, 1, 0, 1'b0, 1'b0);
    idle(2);

    req_board0 = rand_board(); req_board1 = rand_board();
    run(2'b11, 3, 2, 0, 0, 1'b0, 1'b1);

    req_board1 = rook_board();
    run(2'b10, 1, 2, 3, 0, 1'b0, 1'b0);

    req_board0 = rand_board(); req_board1 = rand_board();
    run(2'b01, 1, 2, 0, 10, 1'b0, 1'b0);
    run(2'b10, 1, 2, 0, 0, 1'b0, 1'b0);

    run(2'b01, 1, NEVER, 5, 0, 1'b0, 1'b0);
    idle(4);
    run(2'b01, 1, 20, 5, 0, 1'b0, 1'b0);
    idle(10);
    run(2'b10, 1, TIMEOUT - 1, 0, 0, 1'b0, 1'b0);
    run(2'b10, 1, TIMEOUT, 5, 0, 1'b0, 1'b0);
    idle(4);

    // Reset while the scan sits in WAIT; its array result arrives later and must be ignored.
    req_board0 = rand_board(); next_delay = 6; next_tag = 0; req_valid = 2'b01;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!(req_valid[0] && req_ready[0]) && guard < 20);
    if (guard >= 20) bound_hit = 1'b1;
    tick();
    req_valid = 2'b00;
    repeat (2) tick();
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    idle(8);
    req_board1 = rand_board();
    run(2'b10, 1, 2, 0, 0, 1'b0, 1'b0);

    repeat (40) begin
      v = 2'($urandom_range(1, 3));
      req_board0 = rand_board(); req_board1 = rand_board();
      run(v, 1, pick_delay(), 0, ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0, 1'b1, 1'b0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    idle(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
